// File: rtl/irq_pending_collector_if.sv
// Bus bundle for the interrupt pending collector: request/mask/ack inputs
// and the registered pending/irq/grant/merged-count outputs.
interface irq_pending_collector_if #(
   parameter int N     = 4,
   parameter int CNT_W = 8
);
   localparam int IDW = (N > 1) ? $clog2(N) : 1;

   logic [N-1:0]     req;
   logic [N-1:0]     mask;
   logic             ack;
   logic [IDW-1:0]   ack_id;
   logic [N-1:0]     pending;
   logic             irq;
   logic [IDW-1:0]   grant_id;
   logic             grant_vld;
   logic [CNT_W-1:0] merged;

   modport master (
      output req, mask, ack, ack_id,
      input  pending, irq, grant_id, grant_vld, merged
   );

   modport slave (
      input  req, mask, ack, ack_id,
      output pending, irq, grant_id, grant_vld, merged
   );
endinterface

// File: rtl/irq_pending_collector.sv
// Captures rising edges on N request lines as sticky pending bits, raises a
// registered irq with the lowest enabled pending index, and counts merged events.
module irq_pending_collector #(
   parameter int N     = 4,
   parameter int CNT_W = 8
) (
   input logic                    clk,
   input logic                    rst,
   irq_pending_collector_if.slave bus
);
   localparam int IDW  = (N > 1) ? $clog2(N) : 1;
   localparam int INCW = $clog2(N + 1);
   localparam int SUMW = ((CNT_W > INCW) ? CNT_W : INCW) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [N-1:0]     r_reqQ;
   logic [N-1:0]     r_pending;
   logic             r_irq;
   logic             r_grantVld;
   logic [IDW-1:0]   r_grantId;
   logic [CNT_W-1:0] r_merged;

   logic [N-1:0]     w_edge;
   logic [N-1:0]     w_clr;
   logic [N-1:0]     w_merge;
   logic [N-1:0]     w_pendingNext;
   logic [N-1:0]     w_active;
   logic             w_any;
   logic [IDW-1:0]   w_lowId;
   logic [INCW-1:0]  w_mergeInc;
   logic [SUMW-1:0]  w_sum;
   logic [CNT_W-1:0] w_mergedNext;

   assign w_edge = bus.req & ~r_reqQ;

   // Ids that do not name a real line (possible when N is not a power of two) match nothing
   always_comb begin
      w_clr = '0;
      if (bus.ack) begin
         for (int i = 0; i < N; i++) begin
            if (bus.ack_id == IDW'(i)) begin
               w_clr[i] = 1'b1;
            end
         end
      end
   end

   // A new edge beats a same-cycle ack so no event is ever lost
   assign w_pendingNext = w_edge | (r_pending & ~w_clr);
   assign w_merge       = w_edge & r_pending & ~w_clr;

   always_comb begin
      w_mergeInc = '0;
      for (int i = 0; i < N; i++) begin
         w_mergeInc = w_mergeInc + INCW'(w_merge[i]);
      end
   end

   assign w_sum        = SUMW'(r_merged) + SUMW'(w_mergeInc);
   assign w_mergedNext = (w_sum > SUMW'(CNT_MAX)) ? CNT_MAX : w_sum[CNT_W-1:0];

   assign w_active = r_pending & bus.mask;
   assign w_any    = |w_active;

   always_comb begin
      w_lowId = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (w_active[i]) begin
            w_lowId = IDW'(i);
         end
      end
   end

   // Edge history resets to all ones so lines already high at release are not events
   always_ff @(posedge clk) begin
      if (rst) begin
         r_reqQ     <= '1;
         r_pending  <= '0;
         r_irq      <= 1'b0;
         r_grantVld <= 1'b0;
         r_grantId  <= '0;
         r_merged   <= '0;
      end else begin
         r_reqQ     <= bus.req;
         r_pending  <= w_pendingNext;
         r_irq      <= w_any;
         r_grantVld <= w_any;
         r_grantId  <= w_lowId;
         r_merged   <= w_mergedNext;
      end
   end

   assign bus.pending   = r_pending;
   assign bus.irq       = r_irq;
   assign bus.grant_vld = r_grantVld;
   assign bus.grant_id  = r_grantId;
   assign bus.merged    = r_merged;

   a_vldMatchesIrq : assert property (@(posedge clk) r_grantVld == r_irq);
   a_mergedMonotonic : assert property (@(posedge clk) disable iff (rst)
      1'b1 |=> (r_merged >= $past(r_merged)));
endmodule

// File: tb/tb_irq_pending_collector.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// behavioural model; a second instance with a 2-bit counter checks saturation.
module tb_irq_pending_collector;
   localparam int N = 4;

   logic clk;
   logic rst;
   int   nPass  = 0;
   int   nTotal = 0;

   irq_pending_collector_if #(.N(N), .CNT_W(8)) bus ();
   irq_pending_collector_if #(.N(N), .CNT_W(2)) busS ();

   assign busS.req    = bus.req;
   assign busS.mask   = bus.mask;
   assign busS.ack    = bus.ack;
   assign busS.ack_id = bus.ack_id;

   irq_pending_collector #(.N(N), .CNT_W(8)) dut  (.clk(clk), .rst(rst), .bus(bus));
   irq_pending_collector #(.N(N), .CNT_W(2)) dutS (.clk(clk), .rst(rst), .bus(busS));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: per-line sticky flags and event counts derived from the rules
   bit mPend [N];
   bit mPrev [N];
   int mIrq, mGid, mMerged, mMergedS, mHits, mFirst;
   bit mEdge, mClr;

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N; i++) begin mPend[i] = 0; mPrev[i] = 1; end
         mIrq = 0; mGid = 0; mMerged = 0; mMergedS = 0;
      end else begin
         mFirst = -1;
         for (int i = 0; i < N; i++)
            if (mPend[i] && bus.mask[i] && mFirst < 0) mFirst = i;
         mIrq = (mFirst >= 0) ? 1 : 0;
         mGid = (mFirst >= 0) ? mFirst : 0;
         mHits = 0;
         for (int i = 0; i < N; i++) begin
            mEdge = bus.req[i] && !mPrev[i];
            mClr  = bus.ack && (int'(bus.ack_id) == i);
            if (mEdge && mPend[i] && !mClr) mHits++;
            if (mEdge) mPend[i] = 1;
            else if (mClr) mPend[i] = 0;
            mPrev[i] = bus.req[i];
         end
         mMerged  = (mMerged + mHits > 255) ? 255 : mMerged + mHits;
         mMergedS = (mMergedS + mHits > 3) ? 3 : mMergedS + mHits;
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic applyStimulus(input logic [N-1:0] r, input logic a, input logic [1:0] id);
      bus.req = r; bus.ack = a; bus.ack_id = id;
      step(1);
   endtask

   task automatic doReset();
      rst = 1'b1; bus.req = '0; bus.ack = 1'b0; bus.mask = 4'hF;
      step(1);
      rst = 1'b0;
      step(1);
   endtask

   task automatic test_reset();
      rst = 1'b1; bus.req = 4'b0010; bus.mask = 4'hF; bus.ack = 1'b0; bus.ack_id = '0;
      step(2);
      nTotal++; if (bus.pending !== 4'b0000) $display("[TB] FAIL reset_pending: got %b expected 0000", bus.pending); else nPass++;
      nTotal++; if (bus.irq !== 1'b0) $display("[TB] FAIL reset_irq: got %b expected 0", bus.irq); else nPass++;
      nTotal++; if (bus.grant_vld !== 1'b0) $display("[TB] FAIL reset_vld: got %b expected 0", bus.grant_vld); else nPass++;
      nTotal++; if (bus.grant_id !== 2'd0) $display("[TB] FAIL reset_gid: got %0d expected 0", bus.grant_id); else nPass++;
      nTotal++; if (bus.merged !== 8'd0) $display("[TB] FAIL reset_merged: got %0d expected 0", bus.merged); else nPass++;
      rst = 1'b0;
      step(5);
      nTotal++; if (bus.pending !== 4'b0000) $display("[TB] FAIL held_line_pending: got %b expected 0000", bus.pending); else nPass++;
      nTotal++; if (bus.irq !== 1'b0) $display("[TB] FAIL held_line_irq: got %b expected 0", bus.irq); else nPass++;
   endtask

   task automatic test_single_edge();
      doReset();
      applyStimulus(4'b0100, 1'b0, 2'd0);
      nTotal++; if (bus.pending !== 4'b0100) $display("[TB] FAIL edge_pending: got %b expected 0100", bus.pending); else nPass++;
      nTotal++; if (bus.irq !== 1'b0) $display("[TB] FAIL edge_irq_latency: got %b expected 0", bus.irq); else nPass++;
      step(1);
      nTotal++; if (bus.irq !== 1'b1) $display("[TB] FAIL edge_irq: got %b expected 1", bus.irq); else nPass++;
      nTotal++; if (bus.grant_id !== 2'd2) $display("[TB] FAIL edge_gid: got %0d expected 2", bus.grant_id); else nPass++;
      nTotal++; if (bus.grant_vld !== 1'b1) $display("[TB] FAIL edge_vld: got %b expected 1", bus.grant_vld); else nPass++;
      applyStimulus(4'b0100, 1'b1, 2'd2);
      nTotal++; if (bus.pending !== 4'b0000) $display("[TB] FAIL ack_pending: got %b expected 0000", bus.pending); else nPass++;
      nTotal++; if (bus.irq !== 1'b1) $display("[TB] FAIL ack_irq_latency: got %b expected 1", bus.irq); else nPass++;
      applyStimulus(4'b0100, 1'b0, 2'd0);
      nTotal++; if (bus.irq !== 1'b0) $display("[TB] FAIL ack_irq: got %b expected 0", bus.irq); else nPass++;
   endtask

   task automatic test_two_lines();
      doReset();
      applyStimulus(4'b1010, 1'b0, 2'd0);
      step(1);
      nTotal++; if (bus.grant_id !== 2'd1) $display("[TB] FAIL two_gid_first: got %0d expected 1", bus.grant_id); else nPass++;
      applyStimulus(4'b1010, 1'b1, 2'd1);
      nTotal++; if (bus.pending !== 4'b1000) $display("[TB] FAIL two_pending: got %b expected 1000", bus.pending); else nPass++;
      applyStimulus(4'b1010, 1'b0, 2'd0);
      nTotal++; if (bus.grant_id !== 2'd3) $display("[TB] FAIL two_gid_second: got %0d expected 3", bus.grant_id); else nPass++;
      applyStimulus(4'b1010, 1'b1, 2'd3);
      applyStimulus(4'b1010, 1'b0, 2'd0);
      nTotal++; if (bus.irq !== 1'b0) $display("[TB] FAIL two_irq_clear: got %b expected 0", bus.irq); else nPass++;
      nTotal++; if (bus.grant_vld !== 1'b0) $display("[TB] FAIL two_vld_clear: got %b expected 0", bus.grant_vld); else nPass++;
   endtask

   task automatic test_set_wins();
      doReset();
      applyStimulus(4'b0100, 1'b0, 2'd0);
      applyStimulus(4'b0000, 1'b0, 2'd0);
      applyStimulus(4'b0100, 1'b1, 2'd2);
      nTotal++; if (bus.pending[2] !== 1'b1) $display("[TB] FAIL setwins_pending: got %b expected 1", bus.pending[2]); else nPass++;
      nTotal++; if (bus.merged !== 8'd0) $display("[TB] FAIL setwins_merged: got %0d expected 0", bus.merged); else nPass++;
      applyStimulus(4'b0000, 1'b0, 2'd0);
      applyStimulus(4'b0001, 1'b0, 2'd0);
      applyStimulus(4'b0000, 1'b0, 2'd0);
      applyStimulus(4'b0001, 1'b0, 2'd0);
      nTotal++; if (bus.merged !== 8'd1) $display("[TB] FAIL merge_count: got %0d expected 1", bus.merged); else nPass++;
      nTotal++; if (bus.pending !== 4'b0101) $display("[TB] FAIL merge_pending: got %b expected 0101", bus.pending); else nPass++;
   endtask

   task automatic test_mask();
      doReset();
      bus.mask = 4'b0000;
      applyStimulus(4'b0001, 1'b0, 2'd0);
      step(1);
      nTotal++; if (bus.pending !== 4'b0001) $display("[TB] FAIL mask_pending: got %b expected 0001", bus.pending); else nPass++;
      nTotal++; if (bus.irq !== 1'b0) $display("[TB] FAIL mask_irq_off: got %b expected 0", bus.irq); else nPass++;
      bus.mask = 4'b0001;
      step(1);
      nTotal++; if (bus.irq !== 1'b1) $display("[TB] FAIL mask_irq_on: got %b expected 1", bus.irq); else nPass++;
      nTotal++; if (bus.grant_id !== 2'd0) $display("[TB] FAIL mask_gid: got %0d expected 0", bus.grant_id); else nPass++;
      bus.mask = 4'b0000;
      step(1);
      nTotal++; if (bus.irq !== 1'b0) $display("[TB] FAIL mask_irq_reoff: got %b expected 0", bus.irq); else nPass++;
      nTotal++; if (bus.pending !== 4'b0001) $display("[TB] FAIL mask_pending_kept: got %b expected 0001", bus.pending); else nPass++;
      bus.mask = 4'hF;
   endtask

   task automatic test_saturate_and_reset();
      doReset();
      applyStimulus(4'b1111, 1'b0, 2'd0);
      applyStimulus(4'b0000, 1'b0, 2'd0);
      applyStimulus(4'b1111, 1'b0, 2'd0);
      nTotal++; if (bus.merged !== 8'd4) $display("[TB] FAIL multi_merge: got %0d expected 4", bus.merged); else nPass++;
      applyStimulus(4'b0000, 1'b0, 2'd0);
      applyStimulus(4'b0001, 1'b0, 2'd0);
      nTotal++; if (bus.merged !== 8'd5) $display("[TB] FAIL merge_five: got %0d expected 5", bus.merged); else nPass++;
      nTotal++; if (busS.merged !== 2'd3) $display("[TB] FAIL merge_saturate: got %0d expected 3", busS.merged); else nPass++;
      rst = 1'b1;
      applyStimulus(4'b1010, 1'b1, 2'd1);
      nTotal++; if (bus.pending !== 4'b0000) $display("[TB] FAIL midreset_pending: got %b expected 0000", bus.pending); else nPass++;
      nTotal++; if (bus.irq !== 1'b0 || bus.grant_vld !== 1'b0) $display("[TB] FAIL midreset_irq: got %b%b expected 00", bus.irq, bus.grant_vld); else nPass++;
      nTotal++; if (bus.merged !== 8'd0 || busS.merged !== 2'd0) $display("[TB] FAIL midreset_merged: got %0d/%0d expected 0/0", bus.merged, busS.merged); else nPass++;
      rst = 1'b0;
      applyStimulus(4'b1010, 1'b0, 2'd0);
      nTotal++; if (bus.pending !== 4'b0000) $display("[TB] FAIL release_high_lines: got %b expected 0000", bus.pending); else nPass++;
   endtask

   task automatic checkOutput(input int cyc);
      logic [N-1:0] expP;
      for (int i = 0; i < N; i++) expP[i] = mPend[i];
      nTotal++;
      if (bus.pending !== expP || bus.irq !== 1'(mIrq) || bus.grant_vld !== 1'(mIrq) ||
          bus.grant_id !== 2'(mGid) || bus.merged !== 8'(mMerged) || busS.merged !== 2'(mMergedS))
         $display("[TB] FAIL random_cycle_%0d: got p=%b irq=%b vld=%b id=%0d m=%0d ms=%0d expected p=%b irq=%0d id=%0d m=%0d ms=%0d",
                  cyc, bus.pending, bus.irq, bus.grant_vld, bus.grant_id, bus.merged, busS.merged,
                  expP, mIrq, mGid, mMerged, mMergedS);
      else nPass++;
   endtask

   task automatic test_random();
      doReset();
      for (int c = 0; c < 400; c++) begin
         rst = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 7) == 0) bus.mask = 4'($urandom);
         applyStimulus(4'($urandom), ($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)));
         checkOutput(c);
      end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; bus.req = '0; bus.mask = 4'hF; bus.ack = 1'b0; bus.ack_id = '0;
      test_reset();
      test_single_edge();
      test_two_lines();
      test_set_wins();
      test_mask();
      test_saturate_and_reset();
      test_random();
      $display("%0d/%0d checks passed", nPass, nTotal);
      $finish;
   end
endmodule
